// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and opcode helpers for the ALU issue/writeback controller.
// Opcode values mirror the ALU group of InstructionSet.v.
package alu_issue_ctrl_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned RF_DEPTH = 8;
  localparam int unsigned RF_AW    = 3;
  localparam int unsigned OP_W     = 5;

  localparam logic [OP_W-1:0] OP_ADD = 5'h00;
  localparam logic [OP_W-1:0] OP_ADC = 5'h01;
  localparam logic [OP_W-1:0] OP_SUB = 5'h02;
  localparam logic [OP_W-1:0] OP_INC = 5'h03;
  localparam logic [OP_W-1:0] OP_DEC = 5'h04;
  localparam logic [OP_W-1:0] OP_AND = 5'h05;
  localparam logic [OP_W-1:0] OP_OR  = 5'h06;
  localparam logic [OP_W-1:0] OP_XOR = 5'h07;
  localparam logic [OP_W-1:0] OP_NOT = 5'h08;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2
  } state_e;

  // Opcodes executed by the ALU; everything else is rejected at issue.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_INC, OP_DEC,
      OP_AND, OP_OR, OP_XOR, OP_NOT: is_alu_op = 1'b1;
      default:                       is_alu_op = 1'b0;
    endcase
  endfunction

  // Arithmetic ops are the only ones allowed to update the carry flag.
  function automatic logic is_arith_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_INC, OP_DEC: is_arith_op = 1'b1;
      default:                                is_arith_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_8x16.sv
// 8x16 register file: one synchronous write port, two operand read ports
// and a debug read port, all reads combinational.
module regfile_8x16
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned NREGS = RF_DEPTH,
  parameter int unsigned W     = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [2:0]       waddr,
  input  logic [W-1:0]     wdata,
  input  logic [2:0]       raddr_a,
  output logic [W-1:0]     rdata_a,
  input  logic [2:0]       raddr_b,
  output logic [W-1:0]     rdata_b,
  input  logic [2:0]       dbg_addr,
  output logic [W-1:0]     dbg_data
);

  logic [W-1:0] mem [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a  = mem[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller in front of the registered 16-bit ALU:
// accept -> one ALU-enable cycle -> writeback of result and C/Z/S flags.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned NREGS = RF_DEPTH,
  parameter int unsigned W     = DATA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [4:0]      instr_op,
  input  logic [2:0]      instr_rd,
  input  logic [2:0]      instr_rs,
  input  logic [2:0]      instr_rt,
  output logic            alu_en,
  output logic [4:0]      alu_op,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  input  logic [W-1:0]    alu_out,
  input  logic            alu_cflag,
  output logic            flag_c,
  output logic            flag_z,
  output logic            flag_s,
  output logic            wb_done,
  output logic            illegal,
  input  logic [2:0]      dbg_addr,
  output logic [W-1:0]    dbg_data
);

  state_e       state, state_nxt;
  logic         accept, legal;
  logic [2:0]   rd_q;
  logic [W-1:0] rs_data, rt_data;

  regfile_8x16 #(
    .NREGS (NREGS),
    .W     (W)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (state == S_WB),
    .waddr    (rd_q),
    .wdata    (alu_out),
    .raddr_a  (instr_rs),
    .rdata_a  (rs_data),
    .raddr_b  (instr_rt),
    .rdata_b  (rt_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    legal     = 1'b0;
    case (state)
      S_IDLE: begin
        accept = instr_valid;
        legal  = instr_valid && is_alu_op(instr_op);
        if (legal) state_nxt = S_ISSUE;
      end
      S_ISSUE: state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake/strobe outputs follow the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_ready <= 1'b1;
      alu_en      <= 1'b0;
      wb_done     <= 1'b0;
      illegal     <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rd_q        <= '0;
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
      flag_s      <= 1'b0;
    end else begin
      instr_ready <= (state_nxt == S_IDLE);
      alu_en      <= (state_nxt == S_ISSUE);
      wb_done     <= (state_nxt == S_WB);
      illegal     <= accept && !legal;
      if (legal) begin
        alu_op <= instr_op;
        alu_a  <= rs_data;
        alu_b  <= rt_data;
        rd_q   <= instr_rd;
      end
      // Logic ops leave carry untouched.
      if (state == S_WB) begin
        flag_z <= (alu_out == '0);
        flag_s <= alu_out[W-1];
        if (is_arith_op(alu_op)) flag_c <= alu_cflag;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural registered ALU.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  instr_op;
  logic [2:0]  instr_rd, instr_rs, instr_rt;
  logic        alu_en;
  logic [4:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic [15:0] alu_out;
  logic        alu_cflag;
  logic        flag_c, flag_z, flag_s;
  logic        wb_done, illegal;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int vectors    = 0;
  int miscompares = 0;

  // Preload override: the ALU returns force_val instead of computing.
  logic        force_en  = 1'b0;
  logic [15:0] force_val = '0;
  logic        model_c;
  logic [16:0] alu_res;

  localparam logic [4:0] OP_ILLEGAL = 5'h10;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs    (instr_rs),
    .instr_rt    (instr_rt),
    .alu_en      (alu_en),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_out     (alu_out),
    .alu_cflag   (alu_cflag),
    .flag_c      (flag_c),
    .flag_z      (flag_z),
    .flag_s      (flag_s),
    .wb_done     (wb_done),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  function automatic logic [16:0] alu_f(input logic [4:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin);
    case (op)
      OP_ADD:  alu_f = {1'b0, a} + {1'b0, b};
      OP_ADC:  alu_f = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      OP_SUB:  alu_f = {(a < b), 16'(a - b)};
      OP_INC:  alu_f = {1'b0, a} + 17'd1;
      OP_DEC:  alu_f = {(a == 16'd0), 16'(a - 16'd1)};
      OP_AND:  alu_f = {1'b0, a & b};
      OP_OR:   alu_f = {1'b0, a | b};
      OP_XOR:  alu_f = {1'b0, a ^ b};
      OP_NOT:  alu_f = {1'b0, ~a};
      default: alu_f = '0;
    endcase
  endfunction

  always_comb alu_res = alu_f(alu_op, alu_a, alu_b, model_c);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out   <= '0;
      alu_cflag <= 1'b0;
      model_c   <= 1'b0;
    end else if (alu_en) begin
      if (force_en) begin
        alu_out   <= force_val;
        alu_cflag <= 1'b0;
      end else begin
        alu_out   <= alu_res[15:0];
        alu_cflag <= alu_res[16];
        model_c   <= alu_res[16];
      end
    end
  end

  // One instruction through the handshake; observes cycles 1..3 after accept.
  task automatic exec(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs,
                      input logic [2:0] rt, output int en_cnt, output int wb_at,
                      output int ill_at, output int rdy_low);
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    en_cnt = 0; wb_at = -1; ill_at = -1; rdy_low = 0;
    for (int c = 1; c <= 3; c++) begin
      if (alu_en) en_cnt++;
      if (wb_done && wb_at < 0) wb_at = c;
      if (illegal && ill_at < 0) ill_at = c;
      if (!instr_ready) rdy_low++;
      @(posedge clk); #1;
    end
  endtask

  task automatic load_reg(input logic [2:0] r, input logic [15:0] v);
    int e, w, il, rl;
    force_en = 1'b1; force_val = v;
    exec(OP_OR, r, 3'd0, 3'd0, e, w, il, rl);
    force_en = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] r, output logic [15:0] v);
    dbg_addr = r; #1;
    v = dbg_data;
  endtask

  task automatic test_reset;
    logic [15:0] v;
    rst = 1'b1; instr_valid = 1'b0; instr_op = '0;
    instr_rd = '0; instr_rs = '0; instr_rt = '0; dbg_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", instr_ready); end
    vectors++; if (alu_en !== 1'b0) begin miscompares++; $display("FAIL reset_alu_en got %b exp 0", alu_en); end
    vectors++; if ({alu_op, alu_a, alu_b} !== 37'd0) begin miscompares++; $display("FAIL reset_alu_bus got %h/%h/%h exp 0", alu_op, alu_a, alu_b); end
    vectors++; if ({flag_c, flag_z, flag_s} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b exp 000", {flag_c, flag_z, flag_s}); end
    vectors++; if ({wb_done, illegal} !== 2'b00) begin miscompares++; $display("FAIL reset_pulses got %b exp 00", {wb_done, illegal}); end
    for (int r = 0; r < 8; r++) begin
      read_reg(3'(r), v);
      vectors++; if (v !== 16'h0000) begin miscompares++; $display("FAIL reset_rf r%0d got %h exp 0000", r, v); end
    end
  endtask

  task automatic test_add_basic;
    int e, w, il, rl;
    logic [15:0] v;
    load_reg(3'd1, 16'h0005);
    load_reg(3'd2, 16'h0003);
    exec(OP_ADD, 3'd3, 3'd1, 3'd2, e, w, il, rl);
    vectors++; if (e !== 1) begin miscompares++; $display("FAIL add_en_cycles got %0d exp 1", e); end
    vectors++; if (w !== 2) begin miscompares++; $display("FAIL add_wb_latency got %0d exp 2", w); end
    vectors++; if (rl !== 2) begin miscompares++; $display("FAIL add_ready_low got %0d exp 2", rl); end
    read_reg(3'd3, v);
    vectors++; if (v !== 16'h0008) begin miscompares++; $display("FAIL add_result got %h exp 0008", v); end
    vectors++; if ({flag_c, flag_z, flag_s} !== 3'b000) begin miscompares++; $display("FAIL add_flags got %b exp 000", {flag_c, flag_z, flag_s}); end
    vectors++; if ({alu_op, alu_a, alu_b} !== {OP_ADD, 16'h0005, 16'h0003}) begin miscompares++; $display("FAIL add_alu_hold got %h/%h/%h exp 00/0005/0003", alu_op, alu_a, alu_b); end
  endtask

  task automatic test_carry_wrap;
    int e, w, il, rl;
    logic [15:0] v;
    load_reg(3'd1, 16'hFFFF);
    load_reg(3'd2, 16'h0001);
    load_reg(3'd6, 16'h00F0);
    load_reg(3'd7, 16'h0F00);
    exec(OP_ADD, 3'd5, 3'd1, 3'd2, e, w, il, rl);
    read_reg(3'd5, v);
    vectors++; if (v !== 16'h0000) begin miscompares++; $display("FAIL wrap_result got %h exp 0000", v); end
    vectors++; if ({flag_c, flag_z, flag_s} !== 3'b110) begin miscompares++; $display("FAIL wrap_flags got %b exp 110", {flag_c, flag_z, flag_s}); end
    exec(OP_AND, 3'd3, 3'd6, 3'd7, e, w, il, rl);
    read_reg(3'd3, v);
    vectors++; if (v !== 16'h0000) begin miscompares++; $display("FAIL and_result got %h exp 0000", v); end
    vectors++; if ({flag_c, flag_z, flag_s} !== 3'b110) begin miscompares++; $display("FAIL and_keeps_c got %b exp 110", {flag_c, flag_z, flag_s}); end
  endtask

  task automatic test_sub_illegal;
    int e, w, il, rl;
    logic [15:0] v;
    load_reg(3'd1, 16'h0001);
    load_reg(3'd2, 16'h0002);
    exec(OP_SUB, 3'd4, 3'd1, 3'd2, e, w, il, rl);
    read_reg(3'd4, v);
    vectors++; if (v !== 16'hFFFF) begin miscompares++; $display("FAIL sub_result got %h exp ffff", v); end
    vectors++; if ({flag_c, flag_z, flag_s} !== 3'b101) begin miscompares++; $display("FAIL sub_flags got %b exp 101", {flag_c, flag_z, flag_s}); end
    exec(OP_ILLEGAL, 3'd4, 3'd2, 3'd2, e, w, il, rl);
    vectors++; if (il !== 1) begin miscompares++; $display("FAIL illegal_pulse got cycle %0d exp 1", il); end
    vectors++; if (e !== 0 || w !== -1) begin miscompares++; $display("FAIL illegal_no_issue got en=%0d wb=%0d exp 0/-1", e, w); end
    vectors++; if (rl !== 0) begin miscompares++; $display("FAIL illegal_ready got low=%0d exp 0", rl); end
    read_reg(3'd4, v);
    vectors++; if (v !== 16'hFFFF) begin miscompares++; $display("FAIL illegal_rf got %h exp ffff", v); end
    vectors++; if ({flag_c, flag_z, flag_s} !== 3'b101) begin miscompares++; $display("FAIL illegal_flags got %b exp 101", {flag_c, flag_z, flag_s}); end
    vectors++; if (alu_op !== OP_SUB) begin miscompares++; $display("FAIL illegal_alu_op_hold got %h exp %h", alu_op, OP_SUB); end
  endtask

  task automatic test_back_to_back;
    int acc[$];
    int lows = 0;
    int k = 0;
    logic rdy;
    logic [15:0] v;
    instr_valid = 1'b1; instr_op = OP_INC;
    instr_rd = 3'd1; instr_rs = 3'd1; instr_rt = 3'd0;
    for (int e = 0; e < 9; e++) begin
      @(negedge clk);
      rdy = instr_ready;
      if (!rdy) lows++;
      if (rdy && instr_valid) acc.push_back(e);
      @(posedge clk); #1;
      if (rdy && instr_valid) begin
        k++;
        if (k < 3) begin
          instr_rd = 3'(k + 1); instr_rs = 3'(k + 1);
        end else begin
          instr_valid = 1'b0;
        end
      end
    end
    vectors++;
    if (acc.size() != 3) begin
      miscompares++; $display("FAIL b2b_accept_count got %0d exp 3", acc.size());
    end else if (acc[0] != 0 || acc[1] != 3 || acc[2] != 6) begin
      miscompares++; $display("FAIL b2b_accept_edges got %0d,%0d,%0d exp 0,3,6", acc[0], acc[1], acc[2]);
    end
    vectors++; if (lows !== 6) begin miscompares++; $display("FAIL b2b_ready_low got %0d exp 6", lows); end
    read_reg(3'd1, v);
    vectors++; if (v !== 16'h0002) begin miscompares++; $display("FAIL b2b_r1 got %h exp 0002", v); end
    read_reg(3'd2, v);
    vectors++; if (v !== 16'h0003) begin miscompares++; $display("FAIL b2b_r2 got %h exp 0003", v); end
    read_reg(3'd3, v);
    vectors++; if (v !== 16'h0001) begin miscompares++; $display("FAIL b2b_r3 got %h exp 0001", v); end
  endtask

  task automatic test_same_reg;
    int e, w, il, rl;
    logic [15:0] v;
    load_reg(3'd4, 16'h0010);
    exec(OP_ADD, 3'd4, 3'd4, 3'd4, e, w, il, rl);
    read_reg(3'd4, v);
    vectors++; if (v !== 16'h0020) begin miscompares++; $display("FAIL same_reg got %h exp 0020", v); end
    vectors++; if ({flag_c, flag_z, flag_s} !== 3'b000) begin miscompares++; $display("FAIL same_reg_flags got %b exp 000", {flag_c, flag_z, flag_s}); end
  endtask

  task automatic test_reset_wb;
    logic [15:0] v;
    exec_sub_flags_setup();
    @(negedge clk);
    instr_valid = 1'b1; instr_op = OP_ADD;
    instr_rd = 3'd6; instr_rs = 3'd1; instr_rt = 3'd2;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (wb_done !== 1'b1) begin miscompares++; $display("FAIL rstwb_in_wb got %b exp 1", wb_done); end
    rst = 1'b1; #1;
    vectors++; if ({wb_done, alu_en, illegal} !== 3'b000) begin miscompares++; $display("FAIL rstwb_strobes got %b exp 000", {wb_done, alu_en, illegal}); end
    vectors++; if ({alu_op, alu_a, alu_b} !== 37'd0) begin miscompares++; $display("FAIL rstwb_alu_bus got %h/%h/%h exp 0", alu_op, alu_a, alu_b); end
    vectors++; if ({flag_c, flag_z, flag_s} !== 3'b000) begin miscompares++; $display("FAIL rstwb_flags got %b exp 000", {flag_c, flag_z, flag_s}); end
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (instr_ready !== 1'b1 || wb_done !== 1'b0) begin miscompares++; $display("FAIL rstwb_release got ready=%b wb=%b exp 1/0", instr_ready, wb_done); end
    read_reg(3'd6, v);
    vectors++; if (v !== 16'h0000) begin miscompares++; $display("FAIL rstwb_rd got %h exp 0000", v); end
  endtask

  // Leaves C and S set so the flag reset below is observable.
  task automatic exec_sub_flags_setup;
    int e, w, il, rl;
    load_reg(3'd1, 16'h0001);
    load_reg(3'd2, 16'h0002);
    exec(OP_SUB, 3'd5, 3'd1, 3'd2, e, w, il, rl);
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_carry_wrap();
    test_sub_illegal();
    test_back_to_back();
    test_same_reg();
    test_reset_wb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue and writeback controller sitting directly upstream of the 16-bit ALU. Accepts one decoded register-register instruction at a time over a valid/ready handshake. Reads operands from an internal 8×16 register file, drives the ALU for one enabled cycle, then captures the registered ALU result and flags. Writes the result back and holds the architectural flag register (C, Z, S) for the branch logic.

## Interface
- `NREGS`, 8: register file depth; index width is fixed at 3.
- `W`, 16: data width; must match the ALU.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_valid` in 1: decoded instruction present.
- `instr_ready` out 1: block can accept; high only in IDLE.
- `instr_op` in 5: opcode, encodings from `InstructionSet.v`.
- `instr_rd`, `instr_rs`, `instr_rt` in 3 each: destination, operand A, operand B.
- `alu_en` out 1: ALU enable.
- `alu_op` out 5: ALU opcode.
- `alu_a`, `alu_b` out 16: ALU operands.
- `alu_out` in 16: ALU result, registered inside the ALU.
- `alu_cflag` in 1: ALU carry.
- `flag_c`, `flag_z`, `flag_s` out 1 each: architectural flags.
- `wb_done` out 1: one-cycle pulse when writeback commits.
- `illegal` out 1: one-cycle pulse when a non-ALU opcode is rejected.
- `dbg_addr` in 3, `dbg_data` out 16: combinational register-file read port.

## Operation
- FSM states: IDLE, ISSUE, WB.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid`, latch op, rd, and operands `rf[rs]` and `rf[rt]`.
  - ALU opcodes (ADD, ADC, SUB, INC, DEC, AND, OR, XOR, NOT) go to ISSUE.
  - Any other opcode pulses `illegal` next cycle and stays in IDLE; there is no register or flag change.
- ISSUE:
  - `alu_en`=1, `alu_op`/`alu_a`/`alu_b` driven from the latched values.
  - The ALU registers its result at the end of this cycle.
  - Next state is WB.
- WB:
  - `alu_out` is valid.
  - At the end of the cycle, `rf[rd]`←`alu_out`.
  - `flag_z`←(`alu_out`==0); `flag_s`←`alu_out[15]`.
  - `flag_c`←`alu_cflag` for ADD/ADC/SUB/INC/DEC only; logic ops preserve `flag_c`.
  - `wb_done`=1 in this cycle. Next state is IDLE.
- Operands are latched at acceptance, so rd==rs==rt is legal and reads pre-write values.
- Unary ops (INC, DEC, NOT) still drive `alu_b`=`rf[rt]`; the ALU ignores it.
- `alu_a`, `alu_b`, `alu_op` hold their values outside ISSUE. `alu_en`=0 outside ISSUE.
- `dbg_data`=`rf[dbg_addr]`, showing pre-write value during WB and the new value from the next cycle.

## Timing
- Throughput: one instruction per 3 cycles. Accept edge T0 → `alu_en` cycle T0+1 → `wb_done` cycle T0+2 → `instr_ready` again cycle T0+3.
- The handshake completes on an edge where `instr_valid`&&`instr_ready`. `instr_valid` may drop without penalty while not ready.
- Reset values:
  - state=IDLE, all rf entries 0.
  - `flag_c`/`flag_z`/`flag_s`=0.
  - `alu_en`=0, `alu_op`=0, `alu_a`=`alu_b`=0.
  - `wb_done`=`illegal`=0.
- Reset mid-ISSUE or mid-WB: abort immediately, no writeback, no flag update. `instr_ready`=1 on the first edge after release.
- Carry wrap-around: 0xFFFF+1 gives result 0x0000, C=1, Z=1, S=0.

## Structure
- State encoding localparams and the ALU-opcode membership / arithmetic-class function belong in a shared package alongside `InstructionSet.v`.
- One natural sub-module: `regfile_8x16`, with one synchronous write port and two combinational read ports plus the debug read port.

## Test plan
- Reset, then ADD r3←r1+r2 with r1=0x0005, r2=0x0003 preloaded → `alu_en` one cycle, `wb_done` 2 cycles after accept, r3=0x0008, flags C=0 Z=0 S=0.
- ADD 0xFFFF+0x0001 → rd=0x0000, C=1, Z=1. Follow with AND 0x00F0&0x0F00 → rd=0, Z=1, C stays 1.
- SUB 0x0001−0x0002 → rd=0xFFFF, S=1, C=1. Then `illegal` opcode → `illegal` pulse, no rf/flag change, `instr_ready` stays 1.
- Back-to-back `instr_valid` held high for 3 instructions → accepts exactly at cycles 0, 3, 6. `instr_ready` low during ISSUE/WB.
- rd=rs=rt=r4 (0x0010), ADD → r4=0x0020.
- Assert `rst` during WB → rd keeps 0 (reset value), no `wb_done`, all outputs at reset values.
